// File: rtl/clock_ctrl.sv
// Key conditioning, 1 Hz prescaler and time-set mode FSM for a digital clock.
// Optional macro CLOCK_CTRL_AUTOREPEAT_EN: a held up/down key repeats one step per second.
`timescale 1ns/1ps
module clock_ctrl #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic       oneSecClk,
    output logic       on,
    output logic       set,
    output logic [1:0] sethms,
    output logic [1:0] upDown
);

    localparam int unsigned HALF_CYC = CLK_HZ / 2;
    localparam int unsigned PS_W     = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [1:0] UD_NONE = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b10;
    localparam logic [1:0] UD_DOWN = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    // key conditioning state
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_key_lvl;
    logic [3:0]      r_key_prev;
    logic [3:0]      r_armed;
    logic [1:0]      r_prime;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [3:0]      w_press;

    // prescaler state
    logic [PS_W-1:0] r_presc;
    logic            r_one_sec;
    logic            w_sec_rise;

    // mode FSM state
    state_t          r_state;
    logic            r_set;
    logic [1:0]      r_sethms;
    logic [1:0]      r_ud;
    logic            r_on;
    logic            r_hit;

    // Synchronize, debounce and arm each key; a key only arms once seen released after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_key_lvl  <= '1;
            r_key_prev <= '1;
            r_armed    <= '0;
            r_prime    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= KEY;
            r_sync2    <= r_sync1;
            r_key_prev <= r_key_lvl;
            r_prime    <= {r_prime[0], 1'b1};
            r_armed    <= r_armed | ({4{r_prime[1]}} & r_sync2);
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_key_lvl[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        r_db_cnt[i]  <= '0;
                        r_key_lvl[i] <= r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_key_prev & ~r_key_lvl & r_armed;

    // Half-second prescaler producing the 1 Hz square wave.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_one_sec <= 1'b0;
        end else if (r_presc == PS_W'(HALF_CYC - 1)) begin
            r_presc   <= '0;
            r_one_sec <= ~r_one_sec;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    assign w_sec_rise = (r_presc == PS_W'(HALF_CYC - 1)) && !r_one_sec;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    logic w_dir_held;
    assign w_dir_held = r_ud[1] ? ~r_key_lvl[1] : ~r_key_lvl[2];
`endif

    // Mode FSM; r_hit marks that a oneSecClk rise has occurred since the step was loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_set    <= 1'b0;
            r_sethms <= 2'b11;
            r_ud     <= UD_NONE;
            r_on     <= 1'b1;
            r_hit    <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && w_press[3]) begin
                r_on <= ~r_on;
            end

            if (w_press[0]) begin
                r_ud  <= UD_NONE;
                r_hit <= 1'b0;
                case (r_state)
                    ST_RUN: begin
                        r_state  <= ST_SET_H;
                        r_set    <= 1'b1;
                        r_sethms <= 2'b00;
                    end
                    ST_SET_H: begin
                        r_state  <= ST_SET_M;
                        r_set    <= 1'b1;
                        r_sethms <= 2'b01;
                    end
                    ST_SET_M: begin
                        r_state  <= ST_SET_S;
                        r_set    <= 1'b1;
                        r_sethms <= 2'b10;
                    end
                    ST_SET_S: begin
                        r_state  <= ST_RUN;
                        r_set    <= 1'b0;
                        r_sethms <= 2'b11;
                    end
                endcase
            end else if (r_state == ST_RUN) begin
                r_ud  <= UD_NONE;
                r_hit <= 1'b0;
            end else if (r_ud == UD_NONE) begin
                if (w_press[1] && !w_press[2]) begin
                    r_ud  <= UD_UP;
                    r_hit <= 1'b0;
                end else if (w_press[2] && !w_press[1]) begin
                    r_ud  <= UD_DOWN;
                    r_hit <= 1'b0;
                end
            end else if (r_hit) begin
                r_hit <= 1'b0;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
                if (!w_dir_held) begin
                    r_ud <= UD_NONE;
                end
`else
                r_ud <= UD_NONE;
`endif
            end else if (w_sec_rise) begin
                r_hit <= 1'b1;
            end
        end
    end

    assign oneSecClk = r_one_sec;
    assign on        = r_on;
    assign set       = r_set;
    assign sethms    = r_sethms;
    assign upDown    = r_ud;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed, table-driven bench for clock_ctrl at CLK_HZ=10, DEBOUNCE_CYC=4.
`timescale 1ns/1ps
module tb_clock_ctrl;

    localparam int UD_NONE = 0;
    localparam int UD_DN   = 1;
    localparam int UD_UP   = 2;

    logic       clk;
    logic       reset;
    logic [3:0] KEY;
    logic       oneSecClk;
    logic       on;
    logic       set;
    logic [1:0] sethms;
    logic [1:0] upDown;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0] key;
        int         cycles;
        int         set;
        int         sethms;
        int         on;
        int         ud;
    } vec_t;

    vec_t tbl [26];

    clock_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .KEY       (KEY),
        .oneSecClk (oneSecClk),
        .on        (on),
        .set       (set),
        .sethms    (sethms),
        .upDown    (upDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press_key(input int idx);
        KEY      = 4'hF;
        KEY[idx] = 1'b0;
        tick(10);
        KEY = 4'hF;
        tick(10);
    endtask

    // Returns just after the clock edge on which oneSecClk went 0->1.
    task automatic wait_rise();
        logic prev;
        int   found;
        found = 0;
        for (int k = 0; k < 15 && found == 0; k++) begin
            prev = oneSecClk;
            tick(1);
            if (!prev && oneSecClk) found = 1;
        end
        chk("rise_wait", found, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{4'b1110,  3, 0, 3, 1, UD_NONE};
        tbl[1]  = '{4'b1111,  8, 0, 3, 1, UD_NONE};
        tbl[2]  = '{4'b1101, 10, 0, 3, 1, UD_NONE};
        tbl[3]  = '{4'b1111, 10, 0, 3, 1, UD_NONE};
        tbl[4]  = '{4'b1110, 10, 1, 0, 1, UD_NONE};
        tbl[5]  = '{4'b1111, 10, 1, 0, 1, UD_NONE};
        tbl[6]  = '{4'b1110, 10, 1, 1, 1, UD_NONE};
        tbl[7]  = '{4'b1111, 10, 1, 1, 1, UD_NONE};
        tbl[8]  = '{4'b1110, 10, 1, 2, 1, UD_NONE};
        tbl[9]  = '{4'b1111, 10, 1, 2, 1, UD_NONE};
        tbl[10] = '{4'b1110, 10, 0, 3, 1, UD_NONE};
        tbl[11] = '{4'b1111, 10, 0, 3, 1, UD_NONE};
        tbl[12] = '{4'b0111, 10, 0, 3, 0, UD_NONE};
        tbl[13] = '{4'b1111, 10, 0, 3, 0, UD_NONE};
        tbl[14] = '{4'b1110, 10, 1, 0, 0, UD_NONE};
        tbl[15] = '{4'b1111, 10, 1, 0, 0, UD_NONE};
        tbl[16] = '{4'b0111, 10, 1, 0, 0, UD_NONE};
        tbl[17] = '{4'b1111, 10, 1, 0, 0, UD_NONE};
        tbl[18] = '{4'b1110, 10, 1, 1, 0, UD_NONE};
        tbl[19] = '{4'b1111, 10, 1, 1, 0, UD_NONE};
        tbl[20] = '{4'b1110, 10, 1, 2, 0, UD_NONE};
        tbl[21] = '{4'b1111, 10, 1, 2, 0, UD_NONE};
        tbl[22] = '{4'b1110, 10, 0, 3, 0, UD_NONE};
        tbl[23] = '{4'b1111, 10, 0, 3, 0, UD_NONE};
        tbl[24] = '{4'b0111, 10, 0, 3, 1, UD_NONE};
        tbl[25] = '{4'b1111, 10, 0, 3, 1, UD_NONE};

        reset = 1'b1;
        KEY   = 4'hF;
        tick(2);
        chk("rst_osc", int'(oneSecClk), 0);
        chk("rst_set", int'(set), 0);
        chk("rst_sethms", int'(sethms), 3);
        chk("rst_on", int'(on), 1);
        chk("rst_ud", int'(upDown), UD_NONE);

        // Prescaler phase after reset release
        reset = 1'b0;
        tick(4);
        chk("osc_edge4", int'(oneSecClk), 0);
        tick(1);
        chk("osc_edge5", int'(oneSecClk), 1);
        tick(4);
        chk("osc_edge9", int'(oneSecClk), 1);
        tick(1);
        chk("osc_edge10", int'(oneSecClk), 0);

        for (int i = 0; i < 26; i++) begin
            KEY = tbl[i].key;
            tick(tbl[i].cycles);
            chk($sformatf("vec%0d_set", i), int'(set), tbl[i].set);
            chk($sformatf("vec%0d_sethms", i), int'(sethms), tbl[i].sethms);
            chk($sformatf("vec%0d_on", i), int'(on), tbl[i].on);
            chk($sformatf("vec%0d_ud", i), int'(upDown), tbl[i].ud);
        end

        // Single up step in SET_M, key pressed right after a oneSecClk rise
        press_key(0);
        press_key(0);
        chk("setm_sethms", int'(sethms), 1);
        wait_rise();
        KEY = 4'b1101;
        for (int j = 1; j <= 11; j++) begin
            tick(1);
            if (j == 6)  chk("up_preload", int'(upDown), UD_NONE);
            if (j == 7)  chk("up_load", int'(upDown), UD_UP);
            if (j == 10) chk("up_at_rise", int'(upDown), UD_UP);
            if (j == 10) chk("osc_rise", int'(oneSecClk), 1);
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
            if (j == 11) chk("up_repeat", int'(upDown), UD_UP);
`else
            if (j == 11) chk("up_clear", int'(upDown), UD_NONE);
`endif
        end
        bad = 0;
        for (int j = 0; j < 30; j++) begin
            tick(1);
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
            if (int'(upDown) != UD_UP) bad++;
`else
            if (int'(upDown) != UD_NONE) bad++;
`endif
        end
        chk("hold_cycles_off_expect", bad, 0);
        KEY = 4'hF;
        tick(25);
        chk("after_hold_ud", int'(upDown), UD_NONE);

        // Simultaneous up+down in SET_H, then down pressed while up pending
        press_key(0);
        press_key(0);
        press_key(0);
        chk("seth_set", int'(set), 1);
        chk("seth_sethms", int'(sethms), 0);
        KEY = 4'b1001;
        bad = 0;
        for (int j = 0; j < 15; j++) begin
            tick(1);
            if (int'(upDown) != UD_NONE) bad++;
        end
        chk("both_ignored", bad, 0);
        KEY = 4'hF;
        tick(15);
        wait_rise();
        KEY = 4'b1101;
        bad = 0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (int'(upDown) == UD_DN || int'(upDown) == 3) bad++;
            if (j == 2) KEY = 4'b1001;
            if (j == 10) chk("pend_up_held", int'(upDown), UD_UP);
`ifndef CLOCK_CTRL_AUTOREPEAT_EN
            if (j == 12) chk("pend_cleared", int'(upDown), UD_NONE);
`endif
        end
        chk("down_while_pending", bad, 0);
        KEY = 4'hF;
        tick(25);
        chk("pend_idle_ud", int'(upDown), UD_NONE);

        // Mode press clears a loaded step in the same update as the state change
        wait_rise();
        KEY = 4'b1101;
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            if (j == 2) KEY = 4'b1100;
            if (j == 8) chk("mclr_loaded", int'(upDown), UD_UP);
            if (j == 8) chk("mclr_sethms_before", int'(sethms), 0);
            if (j == 9) chk("mclr_ud", int'(upDown), UD_NONE);
            if (j == 9) chk("mclr_sethms_after", int'(sethms), 1);
        end
        KEY = 4'hF;
        tick(25);
        chk("mclr_idle_ud", int'(upDown), UD_NONE);

        // Reset while a step is pending
        wait_rise();
        KEY = 4'b1101;
        tick(8);
        chk("mid_loaded", int'(upDown), UD_UP);
        reset = 1'b1;
        KEY   = 4'hF;
        tick(1);
        chk("mid_rst_ud", int'(upDown), UD_NONE);
        chk("mid_rst_set", int'(set), 0);
        chk("mid_rst_sethms", int'(sethms), 3);
        chk("mid_rst_on", int'(on), 1);
        chk("mid_rst_osc", int'(oneSecClk), 0);

        // Mode key held through reset release must not count as a press
        KEY = 4'b1110;
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("held_rst_set", int'(set), 0);
        chk("held_rst_sethms", int'(sethms), 3);
        KEY = 4'hF;
        tick(10);
        KEY = 4'b1110;
        tick(10);
        chk("repress_set", int'(set), 1);
        chk("repress_sethms", int'(sethms), 0);
        KEY = 4'hF;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, board clock frequency in Hz; SHALL be even and >= 4.
REQ-002 Parameter DEBOUNCE_CYC, default 1000000, number of stable cycles required to accept a key change; SHALL be >= 2.
REQ-003 clk  input  1  board clock; the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 KEY  input  4  raw push-buttons, active-low, asynchronous to clk: KEY[0]=mode, KEY[1]=up, KEY[2]=down, KEY[3]=run/stop.
REQ-006 oneSecClk  output  1  1 Hz square wave, 50% duty, registered.
REQ-007 on  output  1  clock run enable for the timekeeping stage.
REQ-008 set  output  1  1 while in a set state.
REQ-009 sethms  output  2  field select: 00 hour, 01 min, 10 sec, 11 none.
REQ-010 upDown  output  2  step request: 10 up, 01 down, 00 none; 11 SHALL never be driven.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after the synchronized level has differed from it for DEBOUNCE_CYC consecutive cycles.
REQ-012 A press event SHALL be a one-cycle internal pulse on the accepted level's transition to pressed (low); release SHALL generate no event.
REQ-013 Prescaler: counter 0..CLK_HZ/2-1; at terminal count it SHALL wrap to 0 and oneSecClk SHALL toggle in the same cycle.
REQ-014 Mode FSM states RUN, SET_H, SET_M, SET_S; a mode press SHALL advance RUN->SET_H->SET_M->SET_S->RUN.
REQ-015 Outputs by state: RUN set=0 sethms=11; SET_H set=1 sethms=00; SET_M set=1 sethms=01; SET_S set=1 sethms=10; registered, valid the cycle after the transition.
REQ-016 A run/stop press SHALL toggle on only in RUN; in set states it SHALL be ignored, and on SHALL retain its value across set states.
REQ-017 In a set state with upDown=00, an up press SHALL load upDown=10 and a down press SHALL load upDown=01, registered one cycle after the press pulse.
REQ-018 A loaded upDown SHALL hold until the first oneSecClk rising toggle (0->1) strictly after the load, then clear to 00 on the following cycle, so the downstream stage samples exactly one step.
REQ-019 Up and down press pulses in the same cycle SHALL both be ignored.
REQ-020 Any up/down press while upDown!=00 SHALL be ignored (no queueing).
REQ-021 A mode press SHALL clear upDown to 00 in the same update as the state change, with priority over any up/down press in that cycle.
REQ-022 In RUN, up/down presses SHALL be ignored and upDown SHALL be 00.
REQ-023 The prescaler SHALL run continuously in all FSM states, unaffected by key activity.

Reset
REQ-024 While reset=1 at a clk edge: oneSecClk=0, prescaler=0, state=RUN, set=0, sethms=11, upDown=00, on=1.
REQ-025 Reset SHALL set synchronizers and accepted key levels to released (1); no press event SHALL fire for a key already held when reset deasserts until it is released and pressed again.
REQ-026 Reset mid-step SHALL drop any pending upDown request.

Configuration
REQ-027 Macro CLOCK_CTRL_AUTOREPEAT_EN defined: when REQ-018 clears upDown while the same key's accepted level is still pressed and the state is a set state, upDown SHALL instead stay loaded for the next oneSecClk rising toggle (one step per second while held).
REQ-028 Macro not defined: exactly one step per press; holding a key SHALL produce no further steps.

Verification (CLK_HZ=10, DEBOUNCE_CYC=4)
REQ-029 Release reset, no keys -> oneSecClk toggles every 5 cycles (first 0->1 at the 5th edge after reset), set=0, sethms=11, on=1, upDown=00.
REQ-030 KEY[0] low for 3 cycles then high -> no state change; held 10 cycles -> SET_H (set=1, sethms=00); three more clean presses -> SET_M, SET_S, RUN.
REQ-031 In SET_M, KEY[1] pressed 10 cycles -> upDown=10 until after the next oneSecClk rise, then 00; without the macro, holding for 30 more cycles -> no further upDown assertion.
REQ-032 In SET_H, KEY[1] and KEY[2] pressed in the same cycle -> upDown stays 00; then KEY[2] released and re-pressed while KEY[1] pending -> ignored.
REQ-033 RUN, KEY[3] press -> on=0; enter SET_H, KEY[3] press -> on stays 0; back to RUN, press -> on=1.
REQ-034 With CLOCK_CTRL_AUTOREPEAT_EN, in SET_S, KEY[2] held 35 cycles -> upDown=01 across 3 consecutive oneSecClk rises, then 00 after release; reset asserted while loaded -> upDown=00, state=RUN next cycle.
